// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped 16-bit interval timer with an 8-bit prescaler,
//               one-shot/continuous modes and an active-low interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
    parameter logic [15:0] BASE_ADDR  = 16'hD000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  wr_data,
    input  logic        wr_enable,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        irq_n
);

    localparam logic [2:0] C_OFF_CTRL     = 3'd0;
    localparam logic [2:0] C_OFF_STATUS   = 3'd1;
    localparam logic [2:0] C_OFF_LATCH_LO = 3'd2;
    localparam logic [2:0] C_OFF_LATCH_HI = 3'd3;
    localparam logic [2:0] C_OFF_COUNT_LO = 3'd4;
    localparam logic [2:0] C_OFF_COUNT_HI = 3'd5;
    localparam logic [2:0] C_OFF_PRESCALE = 3'd6;

    logic                  ctrl_run;
    logic                  ctrl_cont;
    logic                  ctrl_irq_en;
    logic                  running;
    logic                  flag;
    logic [7:0]            latch_lo;
    logic [7:0]            latch_hi;
    logic [15:0]           count;
    logic [7:0]            snap_hi;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;

    logic       hit;
    logic [2:0] offset;
    logic       wr_hit;
    logic       wr_latch_hi;
    logic       pre_match;
    logic       tick;
    logic       expire;
    logic [7:0] rd_mux;

    assign hit         = (address[15:3] == BASE_ADDR[15:3]);
    assign offset      = address[2:0];
    assign wr_hit      = wr_enable & hit;
    assign wr_latch_hi = wr_hit & (offset == C_OFF_LATCH_HI);
    assign pre_match   = (pre_cnt == prescale);
    // A simultaneous LATCH_HI load swallows the tick entirely, expiry included.
    assign tick        = running & pre_match & ~wr_latch_hi;
    // A zero count while running counts as an expiry, so the counter never wraps.
    assign expire      = tick & (count <= 16'd1);
    assign irq_n       = ~(flag & ctrl_irq_en);

    always_comb begin
        rd_mux = 8'h00;
        case (offset)
            C_OFF_CTRL:     rd_mux = {5'b0, ctrl_irq_en, ctrl_cont, ctrl_run};
            C_OFF_STATUS:   rd_mux = {6'b0, running, flag};
            C_OFF_LATCH_LO: rd_mux = latch_lo;
            C_OFF_LATCH_HI: rd_mux = latch_hi;
            C_OFF_COUNT_LO: rd_mux = count[7:0];
            C_OFF_COUNT_HI: rd_mux = snap_hi;
            C_OFF_PRESCALE: rd_mux = 8'(prescale);
            default:        rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_run    <= 1'b0;
            ctrl_cont   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            running     <= 1'b0;
            flag        <= 1'b0;
            latch_lo    <= 8'h00;
            latch_hi    <= 8'h00;
            count       <= 16'h0000;
            snap_hi     <= 8'h00;
            prescale    <= '0;
            pre_cnt     <= '0;
            rd_data     <= 8'h00;
            rd_hit      <= 1'b0;
        end else begin
            rd_hit  <= hit;
            rd_data <= hit ? rd_mux : 8'h00;

            if (hit && offset == C_OFF_COUNT_LO) begin
                snap_hi <= count[15:8];
            end

            if (running) begin
                pre_cnt <= pre_match ? '0 : pre_cnt + 1'b1;
            end

            // Clear is evaluated before expiry so a coincident expiry wins.
            if (wr_hit && offset == C_OFF_STATUS && wr_data[0]) begin
                flag <= 1'b0;
            end

            if (tick) begin
                if (expire) begin
                    flag <= 1'b1;
                    if (ctrl_cont) begin
                        count <= {latch_hi, latch_lo};
                    end else begin
                        count    <= 16'h0000;
                        running  <= 1'b0;
                        ctrl_run <= 1'b0;
                    end
                end else begin
                    count <= count - 16'd1;
                end
            end

            if (wr_hit) begin
                case (offset)
                    C_OFF_CTRL: begin
                        ctrl_run    <= wr_data[0];
                        ctrl_cont   <= wr_data[1];
                        ctrl_irq_en <= wr_data[2];
                        if (!wr_data[0]) begin
                            running <= 1'b0;
                        end else if (count != 16'h0000) begin
                            running <= 1'b1;
                        end
                    end
                    C_OFF_LATCH_LO: latch_lo <= wr_data;
                    C_OFF_LATCH_HI: begin
                        latch_hi <= wr_data;
                        count    <= {wr_data, latch_lo};
                        pre_cnt  <= '0;
                        running  <= ctrl_run;
                    end
                    C_OFF_PRESCALE: prescale <= PRESCALE_W'(wr_data);
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Self-checking bench for bus_timer (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        wr_enable;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        irq_n;

    int checks = 0;
    int errors = 0;

    bus_timer #(.BASE_ADDR(16'hD000), .PRESCALE_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .irq_n     (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        exp_hit;
        logic [7:0]  exp_data;
    } vec_t;

    typedef struct {
        logic       chk;
        logic       hit;
        logic [7:0] data;
        string      name;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[25];

    // One bus cycle: drive away from the edge, expected read pushed now,
    // popped and compared just after the edge that registers it.
    task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d,
                       input logic chk, input logic eh, input logic [7:0] ed,
                       input string name);
        sb_t e;
        @(negedge clk);
        address   = a;
        wr_enable = we;
        wr_data   = d;
        sb.push_back('{chk, eh, ed, name});
        @(posedge clk);
        #1;
        address   = 16'h0000;
        wr_enable = 1'b0;
        wr_data   = 8'h00;
        e = sb.pop_front();
        if (e.chk) begin
            checks++;
            if (rd_hit !== e.hit || rd_data !== e.data) begin
                errors++;
                $display("FAIL %s: got hit=%b data=%02h, expected hit=%b data=%02h",
                         e.name, rd_hit, rd_data, e.hit, e.data);
            end
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b1, d, 1'b0, 1'b0, 8'h00, "wr");
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        bus(a, 1'b0, 8'h00, 1'b1, 1'b1, exp, name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "idle");
    endtask

    task automatic chk_irq(input logic exp, input string name);
        checks++;
        if (irq_n !== exp) begin
            errors++;
            $display("FAIL %s: irq_n got %b, expected %b", name, irq_n, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        address   = 16'h0000;
        wr_data   = 8'h00;
        wr_enable = 1'b0;

        for (int i = 0; i < 8; i++) vecs[i] = '{16'hD000 + 16'(i), 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[8]  = '{16'hD000, 1'b1, 8'hFF, 1'b1, 8'h00};
        vecs[9]  = '{16'hD000, 1'b0, 8'h00, 1'b1, 8'h07};
        vecs[10] = '{16'hD000, 1'b1, 8'h00, 1'b1, 8'h07};
        vecs[11] = '{16'hD002, 1'b1, 8'hA5, 1'b1, 8'h00};
        vecs[12] = '{16'hD002, 1'b1, 8'h5A, 1'b1, 8'hA5};
        vecs[13] = '{16'hD002, 1'b0, 8'h00, 1'b1, 8'h5A};
        vecs[14] = '{16'hD006, 1'b1, 8'h3C, 1'b1, 8'h00};
        vecs[15] = '{16'hD006, 1'b0, 8'h00, 1'b1, 8'h3C};
        vecs[16] = '{16'hD004, 1'b1, 8'h77, 1'b1, 8'h00};
        vecs[17] = '{16'hD005, 1'b1, 8'h77, 1'b1, 8'h00};
        vecs[18] = '{16'hD004, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[19] = '{16'hD007, 1'b1, 8'h99, 1'b1, 8'h00};
        vecs[20] = '{16'hD007, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[21] = '{16'hD001, 1'b1, 8'h01, 1'b1, 8'h00};
        vecs[22] = '{16'hCFFF, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[23] = '{16'hD008, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[24] = '{16'hD001, 1'b0, 8'h00, 1'b1, 8'h00};

        #1;
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== 8'h00 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got hit=%b data=%02h irq_n=%b, expected 0 00 1",
                     rd_hit, rd_data, irq_n);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++)
            bus(vecs[i].addr, vecs[i].we, vecs[i].wdata, 1'b1, vecs[i].exp_hit,
                vecs[i].exp_data, $sformatf("vec%0d", i));

        // One-shot, prescale 0: flag exactly 5 cycles after the load edge.
        do_reset();
        wr(16'hD006, 8'h00);
        wr(16'hD002, 8'h05);
        wr(16'hD000, 8'h05);
        rd(16'hD000, 8'h05, "oneshot_ctrl_pre");
        wr(16'hD003, 8'h00);
        idle(4);
        chk_irq(1'b1, "oneshot_before_expiry");
        idle(1);
        chk_irq(1'b0, "oneshot_at_expiry");
        rd(16'hD001, 8'h01, "oneshot_status");
        rd(16'hD000, 8'h04, "oneshot_ctrl_post");
        rd(16'hD004, 8'h00, "oneshot_count_zero");
        wr(16'hD001, 8'h01);
        chk_irq(1'b1, "oneshot_clear");
        rd(16'hD001, 8'h00, "oneshot_status_cleared");

        // Continuous, prescale 3, latch 2: expiry every 8 cycles.
        do_reset();
        wr(16'hD006, 8'h03);
        wr(16'hD002, 8'h02);
        wr(16'hD000, 8'h07);
        wr(16'hD003, 8'h00);
        idle(7);
        chk_irq(1'b1, "cont_before_first");
        idle(1);
        chk_irq(1'b0, "cont_first_expiry");
        wr(16'hD001, 8'h01);
        chk_irq(1'b1, "cont_cleared");
        idle(6);
        chk_irq(1'b1, "cont_before_second");
        idle(1);
        chk_irq(1'b0, "cont_second_expiry");
        rd(16'hD004, 8'h02, "cont_count_lo");
        rd(16'hD005, 8'h00, "cont_count_hi");
        wr(16'hD000, 8'h00);
        idle(5);
        rd(16'hD004, 8'h02, "cont_stopped_count");
        rd(16'hD001, 8'h01, "cont_stopped_status");

        // Snapshot coherence across a high-byte borrow.
        do_reset();
        wr(16'hD006, 8'h00);
        wr(16'hD002, 8'h00);
        wr(16'hD000, 8'h01);
        wr(16'hD003, 8'h01);
        rd(16'hD004, 8'h00, "snap_lo");
        idle(2);
        rd(16'hD005, 8'h01, "snap_hi_held");
        rd(16'hD004, 8'hFC, "snap_lo2");
        rd(16'hD005, 8'h00, "snap_hi2");

        // STATUS clear on the expiry cycle: set wins.
        do_reset();
        wr(16'hD006, 8'h00);
        wr(16'hD002, 8'h03);
        wr(16'hD000, 8'h05);
        wr(16'hD003, 8'h00);
        idle(2);
        wr(16'hD001, 8'h01);
        chk_irq(1'b0, "coll_clear_vs_expiry");
        rd(16'hD001, 8'h01, "coll_clear_status");

        // LATCH_HI load on a tick cycle, then CTRL=0 freezes the count.
        do_reset();
        wr(16'hD006, 8'h01);
        wr(16'hD002, 8'h10);
        wr(16'hD000, 8'h01);
        wr(16'hD003, 8'h00);
        idle(2);
        wr(16'hD002, 8'h20);
        wr(16'hD003, 8'h00);
        rd(16'hD004, 8'h20, "coll_load_vs_tick");
        idle(1);
        wr(16'hD000, 8'h00);
        idle(10);
        rd(16'hD004, 8'h1F, "coll_frozen_count");
        rd(16'hD001, 8'h00, "coll_frozen_status");

        // Asynchronous reset mid-count with flag set.
        do_reset();
        wr(16'hD006, 8'h00);
        wr(16'hD002, 8'h02);
        wr(16'hD000, 8'h07);
        wr(16'hD003, 8'h00);
        idle(2);
        wr(16'hD002, 8'h33);
        wr(16'hD003, 8'h00);
        rd(16'hD001, 8'h03, "prereset_status");
        rd(16'hD004, 8'h32, "prereset_count");
        chk_irq(1'b0, "prereset_irq");
        rd(16'hD001, 8'h03, "prereset_status2");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== 8'h00 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got hit=%b data=%02h irq_n=%b, expected 0 00 1",
                     rd_hit, rd_data, irq_n);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(16'hD001, 8'h00, "postreset_status");
        rd(16'hD004, 8'h00, "postreset_count");
        rd(16'hD002, 8'h00, "postreset_latch_lo");
        chk_irq(1'b1, "postreset_irq");
        bus(16'hCFFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, "oow_below");
        bus(16'hD008, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, "oow_above");
        rd(16'hD000, 8'h00, "oow_ctrl_unchanged");
        rd(16'hD006, 8'h00, "oow_prescale_unchanged");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
